// File: rtl/adc_spi_pkg.sv
// rtl/adc_spi_pkg.sv - shared FSM states and command/scan helpers for adc_spi_scan
package adc_spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, LATCH, GAP} state_t;

  // Right-aligned command word: start, sgl_diff, channel MSB-first, optional MSBF.
  function automatic logic [5:0] build_cmd(input logic sgl, input logic [2:0] ch,
                                           input int ch_w, input int msbf);
    logic [5:0] c;
    logic [2:0] chs;
    c   = 6'b000001;
    c   = {c[4:0], sgl};
    chs = ch << (3 - ch_w);
    for (int i = 0; i < 3; i++) begin
      if (i < ch_w) begin
        c   = {c[4:0], chs[2]};
        chs = chs << 1;
      end
    end
    if (msbf != 0) c = {c[4:0], 1'b1};
    return c;
  endfunction

  // First set mask bit at or after ptr, wrapping modulo num_ch.
  function automatic logic [2:0] next_ch(input logic [7:0] mask, input logic [2:0] ptr,
                                         input int num_ch);
    logic [2:0] res;
    logic [2:0] i3;
    int idx;
    res = ptr;
    for (int k = 7; k >= 0; k--) begin
      idx = (int'(ptr) + k) % num_ch;
      i3  = 3'(idx);
      if (k < num_ch && mask[i3]) res = i3;
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_spi_scan_sck_gen.sv
// rtl/adc_spi_scan_sck_gen.sv - SCK divider with one-clk rise/fall strobes
module adc_spi_scan_sck_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             tc;

  // Strobes mark the clk edge on which sck itself toggles.
  assign tc   = en && (cnt == CNT_W'(CLK_DIV - 1));
  assign rise = tc && !sck;
  assign fall = tc && sck;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tc) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/adc_spi_scan.sv
// rtl/adc_spi_scan.sv - scanning SPI ADC reader with tagged valid/ready output
module adc_spi_scan
  import adc_spi_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int NUM_CH    = 2,
  parameter int CLK_DIV   = 8,
  parameter int MSBF_BIT  = 1,
  parameter int NULL_BITS = 1,
  parameter int CS_IDLE   = 4,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              scan_en,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              sgl_diff,
  output logic              sck,
  output logic              sdo,
  input  logic              sdi,
  output logic              chip_en,
  output logic [DATA_W-1:0] data_out,
  output logic [CH_W-1:0]   data_ch,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              overrun,
  output logic              busy
);
  localparam int CMD_LEN   = 2 + CH_W + MSBF_BIT;
  localparam int PRE_LEN   = CMD_LEN + NULL_BITS;
  localparam int FRAME_LEN = PRE_LEN + DATA_W;
  localparam int BC_W      = $clog2(FRAME_LEN + 1);
  localparam int TMR_MAX   = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);

  state_t             state, state_n;
  logic [CH_W-1:0]    scan_ptr, cur_ch, ch_pick, scan_ch;
  logic [CMD_LEN-1:0] cmd_w, cmd_sr;
  logic [DATA_W-1:0]  shreg;
  logic [BC_W-1:0]    bit_cnt;
  logic [TMR_W-1:0]   tmr;
  logic               rise, fall, sck_en;

  assign scan_ch = CH_W'(next_ch(8'(ch_mask), 3'(scan_ptr), NUM_CH));
  assign cmd_w   = CMD_LEN'(build_cmd(sgl_diff, 3'(ch_pick), CH_W, MSBF_BIT));
  assign sck_en  = (state == SHIFT);
  assign busy    = ~chip_en;

  adc_spi_scan_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk  (clk),
    .reset(reset),
    .en   (sck_en),
    .sck  (sck),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    ch_pick = ch_sel;
    case (state)
      IDLE: begin
        if (scan_en && |ch_mask) begin
          state_n = SETUP;
          ch_pick = scan_ch;
        end else if (start) begin
          state_n = SETUP;
        end
      end
      SETUP: if (tmr == TMR_W'(CLK_DIV - 1)) state_n = SHIFT;
      SHIFT: if (fall && bit_cnt == BC_W'(FRAME_LEN)) state_n = LATCH;
      LATCH: state_n = GAP;
      GAP:   if (tmr == TMR_W'(CS_IDLE - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sdo        <= 1'b0;
      chip_en    <= 1'b1;
      data_out   <= '0;
      data_ch    <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      scan_ptr   <= '0;
      cur_ch     <= '0;
      cmd_sr     <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      tmr        <= '0;
    end else begin
      chip_en <= !(state_n == SETUP || state_n == SHIFT);
      tmr     <= (state_n != state) ? '0 : tmr + TMR_W'(1);

      // Command bit goes out on SETUP entry, then advances on each SCK fall; zero-filled afterwards.
      if (state == IDLE && state_n == SETUP) begin
        cur_ch <= ch_pick;
        sdo    <= cmd_w[CMD_LEN-1];
        cmd_sr <= cmd_w << 1;
      end else if (sck_en && fall) begin
        sdo    <= cmd_sr[CMD_LEN-1];
        cmd_sr <= cmd_sr << 1;
      end

      if (!sck_en) begin
        bit_cnt <= '0;
      end else if (rise) begin
        bit_cnt <= bit_cnt + BC_W'(1);
        if (bit_cnt >= BC_W'(PRE_LEN)) shreg <= {shreg[DATA_W-2:0], sdi};
      end

      if (state == LATCH) begin
        data_out   <= shreg;
        data_ch    <= cur_ch;
        data_valid <= 1'b1;
        scan_ptr   <= cur_ch + CH_W'(1);
        if (data_valid && !data_ready) overrun <= 1'b1;
        else if (data_valid)           overrun <= 1'b0;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_adc_spi_scan.sv
// tb/tb_adc_spi_scan.sv - directed bench for adc_spi_scan (default and 8-channel builds)
module tb_adc_spi_scan;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic start_a = 0, scan_en_a = 0, sgl_a = 0, data_ready_a = 0;
  logic [1:0] ch_mask_a = '0;
  logic [0:0] ch_sel_a = '0;
  logic sck_a, sdo_a, chip_en_a, data_valid_a, overrun_a, busy_a;
  logic sdi_a = 0;
  logic [11:0] data_out_a;
  logic [0:0] data_ch_a;

  logic start_b = 0, scan_en_b = 0, sgl_b = 0, data_ready_b = 0;
  logic [7:0] ch_mask_b = '0;
  logic [2:0] ch_sel_b = '0;
  logic sck_b, sdo_b, chip_en_b, data_valid_b, overrun_b, busy_b;
  logic sdi_b = 0;
  logic [11:0] data_out_b;
  logic [2:0] data_ch_b;

  adc_spi_scan #(.CLK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .scan_en(scan_en_a), .ch_mask(ch_mask_a),
    .ch_sel(ch_sel_a), .sgl_diff(sgl_a), .sck(sck_a), .sdo(sdo_a), .sdi(sdi_a),
    .chip_en(chip_en_a), .data_out(data_out_a), .data_ch(data_ch_a), .data_valid(data_valid_a),
    .data_ready(data_ready_a), .overrun(overrun_a), .busy(busy_a)
  );

  adc_spi_scan #(.NUM_CH(8), .MSBF_BIT(0), .CLK_DIV(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .scan_en(scan_en_b), .ch_mask(ch_mask_b),
    .ch_sel(ch_sel_b), .sgl_diff(sgl_b), .sck(sck_b), .sdo(sdo_b), .sdi(sdi_b),
    .chip_en(chip_en_b), .data_out(data_out_b), .data_ch(data_ch_b), .data_valid(data_valid_b),
    .data_ready(data_ready_b), .overrun(overrun_b), .busy(busy_b)
  );

  // ADC model A: 4 command bits, 1 null bit, 12 data bits; channel decoded from the command.
  logic [11:0] word_a [2];
  int rc_a = 0, last_rc_a = 0, hi_a = 0, min_hi_a = 1000;
  logic [3:0] cmd_a = '0, last_cmd_a = '0, bi_a;
  logic sck_pa = 0, ce_pa = 1;
  time fall17_a = 0;
  always @(negedge clk) begin
    if (!chip_en_a && sck_a && !sck_pa) begin
      rc_a++;
      if (rc_a <= 4) cmd_a = {cmd_a[2:0], sdo_a};
    end
    if (!sck_a && sck_pa) begin
      if (rc_a == 17) fall17_a = $time;
      if (rc_a >= 5 && rc_a < 17) begin
        bi_a  = 4'(16 - rc_a);
        sdi_a = word_a[cmd_a[1]][bi_a];
      end
    end
    if (chip_en_a && !ce_pa) begin
      last_rc_a  = rc_a;
      last_cmd_a = cmd_a;
    end
    if (chip_en_a) begin
      rc_a = 0; cmd_a = '0; sdi_a = 0; hi_a++;
    end else if (ce_pa) begin
      if (hi_a < min_hi_a) min_hi_a = hi_a;
      hi_a = 0;
    end
    sck_pa = sck_a;
    ce_pa  = chip_en_a;
  end

  // ADC model B: 5 command bits (no MSBF), 1 null bit, 12 data bits.
  logic [11:0] word_b [8];
  int rc_b = 0, last_rc_b = 0;
  logic [4:0] cmd_b = '0, last_cmd_b = '0;
  logic [3:0] bi_b;
  logic sck_pb = 0, ce_pb = 1;
  always @(negedge clk) begin
    if (!chip_en_b && sck_b && !sck_pb) begin
      rc_b++;
      if (rc_b <= 5) cmd_b = {cmd_b[3:0], sdo_b};
    end
    if (!sck_b && sck_pb && rc_b >= 6 && rc_b < 18) begin
      bi_b  = 4'(17 - rc_b);
      sdi_b = word_b[cmd_b[2:0]][bi_b];
    end
    if (chip_en_b && !ce_pb) begin
      last_rc_b  = rc_b;
      last_cmd_b = cmd_b;
    end
    if (chip_en_b) begin
      rc_b = 0; cmd_b = '0; sdi_b = 0;
    end
    sck_pb = sck_b;
    ce_pb  = chip_en_b;
  end

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (chip_en_a !== 1'b1) begin n_fail++; $display("FAIL reset_chip_en: got %b exp 1", chip_en_a); end
    n_chk++; if (sck_a !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b exp 0", sck_a); end
    n_chk++; if (sdo_a !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %b exp 0", sdo_a); end
    n_chk++; if (data_out_a !== 12'h000) begin n_fail++; $display("FAIL reset_data_out: got %h exp 000", data_out_a); end
    n_chk++; if (data_ch_a !== 1'b0) begin n_fail++; $display("FAIL reset_data_ch: got %h exp 0", data_ch_a); end
    n_chk++; if (data_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", data_valid_a); end
    n_chk++; if (overrun_a !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b exp 0", overrun_a); end
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy_a); end
    n_chk++; if (chip_en_b !== 1'b1) begin n_fail++; $display("FAIL reset_chip_en_b: got %b exp 1", chip_en_b); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_one_shot;
    int t;
    word_a[1] = 12'hA5C; ch_sel_a = 1'b1; sgl_a = 1'b1; data_ready_a = 0; scan_en_a = 0;
    start_a = 1;
    t = 0; while (!busy_a && t < 20) begin @(negedge clk); t++; end
    start_a = 0;
    t = 0; while (!data_valid_a && t < 300) begin @(negedge clk); t++; end
    n_chk++; if (data_valid_a !== 1'b1) begin n_fail++; $display("FAIL t1_valid_timeout: got %b exp 1", data_valid_a); end
    n_chk++; if (data_out_a !== 12'hA5C) begin n_fail++; $display("FAIL t1_data: got %h exp a5c", data_out_a); end
    n_chk++; if (data_ch_a !== 1'b1) begin n_fail++; $display("FAIL t1_ch: got %h exp 1", data_ch_a); end
    n_chk++; if (last_rc_a != 17) begin n_fail++; $display("FAIL t1_rises: got %0d exp 17", last_rc_a); end
    n_chk++; if (last_cmd_a !== 4'b1111) begin n_fail++; $display("FAIL t1_cmd: got %b exp 1111", last_cmd_a); end
    n_chk++; if (($time - fall17_a) != 64'd10) begin n_fail++; $display("FAIL t1_latency: got %0t exp 10", $time - fall17_a); end
    data_ready_a = 1; @(negedge clk); data_ready_a = 0;
    n_chk++; if (data_valid_a !== 1'b0) begin n_fail++; $display("FAIL t1_accept: got %b exp 0", data_valid_a); end
  endtask

  task automatic test_scan;
    int t, got;
    logic ovr;
    logic [0:0] ech;
    logic [11:0] edat;
    word_a[0] = 12'h001; word_a[1] = 12'hFFF;
    min_hi_a = 1000; ovr = 0; got = 0; t = 0;
    ch_mask_a = 2'b11; data_ready_a = 1; scan_en_a = 1;
    while (got < 3 && t < 1000) begin
      @(negedge clk); t++;
      if (overrun_a) ovr = 1;
      if (data_valid_a && data_ready_a) begin
        ech  = 1'(got % 2);
        edat = ech ? 12'hFFF : 12'h001;
        n_chk++; if (data_ch_a !== ech) begin n_fail++; $display("FAIL t2_ch%0d: got %h exp %h", got, data_ch_a, ech); end
        n_chk++; if (data_out_a !== edat) begin n_fail++; $display("FAIL t2_data%0d: got %h exp %h", got, data_out_a, edat); end
        got++;
      end
    end
    scan_en_a = 0;
    n_chk++; if (got != 3) begin n_fail++; $display("FAIL t2_count: got %0d exp 3", got); end
    n_chk++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL t2_overrun: got %b exp 0", ovr); end
    n_chk++; if (min_hi_a < 4) begin n_fail++; $display("FAIL t2_cs_idle: got %0d exp >=4", min_hi_a); end
    repeat (100) @(negedge clk);
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL t2_drain_busy: got %b exp 0", busy_a); end
  endtask

  task automatic test_overrun;
    int t;
    data_ready_a = 0; ch_mask_a = 2'b11; scan_en_a = 1;
    t = 0; while (!data_valid_a && t < 300) begin @(negedge clk); t++; end
    n_chk++; if (data_ch_a !== 1'b1 || data_out_a !== 12'hFFF) begin n_fail++; $display("FAIL t3_first: got ch %h data %h exp ch 1 data fff", data_ch_a, data_out_a); end
    t = 0; while (!overrun_a && t < 300) begin @(negedge clk); t++; end
    scan_en_a = 0;
    n_chk++; if (overrun_a !== 1'b1) begin n_fail++; $display("FAIL t3_overrun: got %b exp 1", overrun_a); end
    n_chk++; if (data_out_a !== 12'h001) begin n_fail++; $display("FAIL t3_data: got %h exp 001", data_out_a); end
    n_chk++; if (data_ch_a !== 1'b0) begin n_fail++; $display("FAIL t3_ch: got %h exp 0", data_ch_a); end
    n_chk++; if (data_valid_a !== 1'b1) begin n_fail++; $display("FAIL t3_valid: got %b exp 1", data_valid_a); end
    data_ready_a = 1; @(negedge clk); data_ready_a = 0;
    n_chk++; if (data_valid_a !== 1'b0) begin n_fail++; $display("FAIL t3_clear_valid: got %b exp 0", data_valid_a); end
    n_chk++; if (overrun_a !== 1'b0) begin n_fail++; $display("FAIL t3_clear_overrun: got %b exp 0", overrun_a); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_mid_reset;
    int t;
    word_a[1] = 12'h777; ch_sel_a = 1'b1; sgl_a = 1'b1; data_ready_a = 0;
    start_a = 1;
    t = 0; while (!busy_a && t < 20) begin @(negedge clk); t++; end
    start_a = 0;
    t = 0; while (!data_valid_a && t < 300) begin @(negedge clk); t++; end
    repeat (8) @(negedge clk);
    start_a = 1;
    t = 0; while (!busy_a && t < 20) begin @(negedge clk); t++; end
    start_a = 0;
    t = 0; while (rc_a < 7 && t < 300) begin @(negedge clk); t++; end
    n_chk++; if (rc_a != 7) begin n_fail++; $display("FAIL t4_rise7: got %0d exp 7", rc_a); end
    reset = 1; @(negedge clk);
    n_chk++; if (chip_en_a !== 1'b1) begin n_fail++; $display("FAIL t4_chip_en: got %b exp 1", chip_en_a); end
    n_chk++; if (sck_a !== 1'b0) begin n_fail++; $display("FAIL t4_sck: got %b exp 0", sck_a); end
    n_chk++; if (data_valid_a !== 1'b0) begin n_fail++; $display("FAIL t4_valid: got %b exp 0", data_valid_a); end
    n_chk++; if (sdo_a !== 1'b0) begin n_fail++; $display("FAIL t4_sdo: got %b exp 0", sdo_a); end
    reset = 0; @(negedge clk);
    word_a[0] = 12'h3C6; ch_sel_a = 1'b0;
    start_a = 1;
    t = 0; while (!busy_a && t < 20) begin @(negedge clk); t++; end
    start_a = 0;
    t = 0; while (!data_valid_a && t < 300) begin @(negedge clk); t++; end
    n_chk++; if (data_out_a !== 12'h3C6) begin n_fail++; $display("FAIL t4_data: got %h exp 3c6", data_out_a); end
    n_chk++; if (data_ch_a !== 1'b0) begin n_fail++; $display("FAIL t4_ch: got %h exp 0", data_ch_a); end
    n_chk++; if (last_rc_a != 17) begin n_fail++; $display("FAIL t4_rises: got %0d exp 17", last_rc_a); end
    n_chk++; if (last_cmd_a !== 4'b1101) begin n_fail++; $display("FAIL t4_cmd: got %b exp 1101", last_cmd_a); end
    data_ready_a = 1; @(negedge clk); data_ready_a = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_wide_scan;
    int t, got;
    logic [2:0] ech;
    word_b[0] = 12'h123; word_b[7] = 12'hABC;
    ch_mask_b = 8'b1000_0001; sgl_b = 0; data_ready_b = 1; scan_en_b = 1;
    got = 0; t = 0;
    while (got < 3 && t < 1000) begin
      @(negedge clk); t++;
      if (data_valid_b && data_ready_b) begin
        ech = (got == 1) ? 3'd7 : 3'd0;
        n_chk++; if (data_ch_b !== ech) begin n_fail++; $display("FAIL t5_ch%0d: got %0d exp %0d", got, data_ch_b, ech); end
        n_chk++; if (data_out_b !== word_b[ech]) begin n_fail++; $display("FAIL t5_data%0d: got %h exp %h", got, data_out_b, word_b[ech]); end
        n_chk++; if (last_rc_b != 18) begin n_fail++; $display("FAIL t5_rises%0d: got %0d exp 18", got, last_rc_b); end
        if (got == 1) begin
          n_chk++; if (last_cmd_b !== 5'b10111) begin n_fail++; $display("FAIL t5_cmd_ch7: got %b exp 10111", last_cmd_b); end
        end
        got++;
      end
    end
    scan_en_b = 0;
    n_chk++; if (got != 3) begin n_fail++; $display("FAIL t5_count: got %0d exp 3", got); end
    repeat (60) @(negedge clk);
    n_chk++; if (busy_b !== 1'b0 || overrun_b !== 1'b0) begin n_fail++; $display("FAIL t5_idle: got busy %b overrun %b exp 0 0", busy_b, overrun_b); end
  endtask

  task automatic test_start_empty_mask;
    int t, low;
    word_a[1] = 12'h5A5; ch_sel_a = 1'b1; sgl_a = 1'b1; data_ready_a = 1;
    ch_mask_a = 2'b00; scan_en_a = 1; start_a = 1;
    t = 0; while (!busy_a && t < 20) begin @(negedge clk); t++; end
    start_a = 0;
    t = 0; while (!data_valid_a && t < 300) begin @(negedge clk); t++; end
    n_chk++; if (data_valid_a !== 1'b1) begin n_fail++; $display("FAIL t6_valid_timeout: got %b exp 1", data_valid_a); end
    n_chk++; if (data_ch_a !== 1'b1) begin n_fail++; $display("FAIL t6_ch: got %h exp 1", data_ch_a); end
    n_chk++; if (data_out_a !== 12'h5A5) begin n_fail++; $display("FAIL t6_data: got %h exp 5a5", data_out_a); end
    low = 0;
    repeat (100) begin @(negedge clk); if (!chip_en_a) low++; end
    n_chk++; if (low != 0) begin n_fail++; $display("FAIL t6_no_scan: got %0d low cycles exp 0", low); end
    scan_en_a = 0; data_ready_a = 0;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_scan();
    test_overrun();
    test_mid_reset();
    test_wide_scan();
    test_start_empty_mask();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
